dense_layer_seq: RTL and testbench

Parametrised, time-multiplexed fully-connected layer; the successor to the fixed 784x10 parallel hidden layer. LANES MAC lanes process neurons in groups, one input per cycle. Weights, biases and activations come from synchronous-read memories. Results stream out one neuron per beat on a valid/ready port, with optional ReLU. It sits between the input/activation buffer and the next layer or argmax stage.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/mac_lane.sv | 53 +++++
 rtl/dense_layer_seq.sv | 125 ++++++++++++
 tb/tb_dense_layer_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default layer sizes and fixed-point helpers
package nn_pkg;
    typedef enum logic [2:0] {IDLE, ACC, BIAS, FIN, OUT} state_t;
    localparam int NN_N_IN    = 784;
    localparam int NN_N_OUT   = 10;
    localparam int NN_LANES   = 2;
    localparam int NN_DW      = 16;
    localparam int NN_FRAC    = 8;
    localparam int NN_RELU_EN = 1;
    function automatic longint sat_to_dw(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (dw - 1)) - 1;
        lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction
    function automatic longint relu(input longint v);
        return (v < 0) ? longint'(0) : v;
    endfunction
endpackage

// File: rtl/mac_lane.sv
// mac_lane: one neuron accumulator with bias fold-in, saturation and optional ReLU
module mac_lane
    import nn_pkg::*;
#(
    parameter int N_IN    = NN_N_IN,
    parameter int DW      = NN_DW,
    parameter int FRAC    = NN_FRAC,
    parameter int RELU_EN = NN_RELU_EN
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_acc_en,
    input  logic          i_fin,
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_w,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_pre,
    output logic [DW-1:0] o_act
);
    localparam int ACCW = 2 * DW + $clog2(N_IN) + 1;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_bias_ext;
    logic signed [ACCW-1:0] w_sum;
    logic signed [ACCW-1:0] w_shr;
    logic signed [ACCW-1:0] r_acc;
    logic signed [DW-1:0]   w_sat;
    logic signed [DW-1:0]   w_act;
    assign w_prod     = $signed(i_x) * $signed(i_w);
    assign w_prod_ext = {{(ACCW - 2 * DW){w_prod[2*DW-1]}}, w_prod};
    assign w_bias_ext = {{(ACCW - DW - FRAC){i_b[DW-1]}}, i_b, {FRAC{1'b0}}};
    assign w_sum      = r_acc + w_bias_ext;
    assign w_shr      = w_sum >>> FRAC;
    assign w_sat      = DW'(sat_to_dw(longint'(w_shr), DW));
    assign w_act      = (RELU_EN != 0) ? DW'(relu(longint'(w_sat))) : w_sat;
    // Clear at group start, sum products, then fold in bias and latch the result
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
            o_pre <= '0;
            o_act <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end else if (i_fin) begin
            r_acc <= w_sum;
            o_pre <= w_sat;
            o_act <= w_act;
        end
    end
endmodule

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer streaming one neuron per beat
module dense_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN    = NN_N_IN,
    parameter int N_OUT   = NN_N_OUT,
    parameter int LANES   = NN_LANES,
    parameter int DW      = NN_DW,
    parameter int FRAC    = NN_FRAC,
    parameter int RELU_EN = NN_RELU_EN,
    localparam int XAW    = $clog2(N_IN),
    localparam int WAW    = $clog2(N_IN * N_OUT / LANES),
    localparam int G      = N_OUT / LANES,
    localparam int GW     = (G > 1) ? $clog2(G) : 1,
    localparam int IW     = $clog2(N_OUT),
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    output logic [XAW-1:0]      x_addr,
    input  logic [DW-1:0]       x_rdata,
    output logic [WAW-1:0]      w_addr,
    input  logic [LANES*DW-1:0] w_rdata,
    output logic [GW-1:0]       b_addr,
    input  logic [LANES*DW-1:0] b_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [DW-1:0]       out_pre,
    output logic [IW-1:0]       out_idx,
    output logic                out_last,
    output logic                done
);
    state_t         r_state;
    logic [XAW-1:0] r_i;
    logic [GW-1:0]  r_g;
    logic [LW-1:0]  r_l;
    logic           r_acc_en;
    logic           r_done;
    logic           w_clear;
    logic           w_fin;
    logic           w_last_lane;
    logic           w_last_group;
    logic [DW-1:0]  w_pre [LANES];
    logic [DW-1:0]  w_act [LANES];
    assign w_last_lane  = r_l == LW'(LANES - 1);
    assign w_last_group = r_g == GW'(G - 1);
    assign w_clear      = (r_state == IDLE && start_valid) || (r_state == OUT && out_ready && w_last_lane && !w_last_group);
    assign w_fin        = r_state == FIN;
    assign start_ready  = r_state == IDLE;
    assign out_valid    = r_state == OUT;
    assign x_addr       = r_i;
    assign w_addr       = WAW'(r_g) * WAW'(N_IN) + WAW'(r_i);
    assign b_addr       = r_g;
    assign out_idx      = IW'(r_g) * IW'(LANES) + IW'(r_l);
    assign out_last     = out_valid && out_idx == IW'(N_OUT - 1);
    assign out_data     = w_act[r_l];
    assign out_pre      = w_pre[r_l];
    assign done         = r_done;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(.N_IN(N_IN), .DW(DW), .FRAC(FRAC), .RELU_EN(RELU_EN)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .i_clear  (w_clear),
            .i_acc_en (r_acc_en),
            .i_fin    (w_fin),
            .i_x      (x_rdata),
            .i_w      (w_rdata[l*DW +: DW]),
            .i_b      (b_rdata[l*DW +: DW]),
            .o_pre    (w_pre[l]),
            .o_act    (w_act[l])
        );
    end
    // Sequencer: walk inputs per group, then bias, finish, and drain lanes one beat at a time
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_i      <= '0;
            r_g      <= '0;
            r_l      <= '0;
            r_acc_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_acc_en <= r_state == ACC;
            case (r_state)
                IDLE: if (start_valid) begin
                    r_state <= ACC;
                    r_i     <= '0;
                    r_g     <= '0;
                    r_l     <= '0;
                end
                ACC: begin
                    r_i <= r_i + 1'b1;
                    if (r_i == XAW'(N_IN - 1)) begin
                        r_i     <= '0;
                        r_state <= BIAS;
                    end
                end
                BIAS: r_state <= FIN;
                FIN: begin
                    r_l     <= '0;
                    r_state <= OUT;
                end
                OUT: if (out_ready) begin
                    if (!w_last_lane) begin
                        r_l <= r_l + 1'b1;
                    end else if (!w_last_group) begin
                        r_l     <= '0;
                        r_g     <= r_g + 1'b1;
                        r_state <= ACC;
                    end else begin
                        r_l     <= '0;
                        r_g     <= '0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed checks of the sequential dense layer with 4 inputs, 4 neurons, 2 lanes
module tb_dense_layer_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  x_addr;
    logic [15:0] x_rdata;
    logic [2:0]  w_addr;
    logic [31:0] w_rdata;
    logic [0:0]  b_addr;
    logic [31:0] b_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] out_pre;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        done;

    logic [15:0] x_mem [4];
    logic [31:0] w_mem [8];
    logic [31:0] b_mem [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [15:0] got_pre  [4];
    logic signed [15:0] got_data [4];
    logic [1:0]         got_idx  [4];
    logic               got_last [4];
    int                 beat_cyc [4];
    int                 beats, dones, lat, unstable, tmo;
    logic               done_first;

    dense_layer_seq #(.N_IN(4), .N_OUT(4), .LANES(2), .DW(16), .FRAC(8), .RELU_EN(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .x_addr      (x_addr),
        .x_rdata     (x_rdata),
        .w_addr      (w_addr),
        .w_rdata     (w_rdata),
        .b_addr      (b_addr),
        .b_rdata     (b_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pre     (out_pre),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        x_rdata <= x_mem[x_addr];
        w_rdata <= w_mem[w_addr];
        b_rdata <= b_mem[b_addr];
    end

    task automatic load_basic(input logic [15:0] xv);
        for (int i = 0; i < 4; i++) begin
            x_mem[i]     = xv;
            w_mem[i]     = {-16'sd256, 16'sd128};
            w_mem[4 + i] = {16'sh8100, 16'sd32512};
        end
        b_mem[0] = {16'd0, 16'd64};
        b_mem[1] = 32'd0;
    endtask

    task automatic load_mixed;
        x_mem[0] = 16'd256;
        x_mem[1] = 16'hFE00;
        x_mem[2] = 16'd128;
        x_mem[3] = 16'd0;
        for (int i = 0; i < 4; i++) w_mem[i] = {16'd1, 16'd256};
        w_mem[4] = {16'd0, 16'd512};
        w_mem[5] = {16'd256, 16'd0};
        w_mem[6] = {16'd256, 16'd0};
        w_mem[7] = 32'd0;
        b_mem[0] = {16'd0, 16'hFFFE};
        b_mem[1] = {16'd400, 16'd3};
    endtask

    task automatic run_pass(input int stall);
        int          cyc;
        logic [15:0] s_pre, s_data;
        logic [1:0]  s_idx;
        logic        s_last;
        beats = 0; dones = 0; lat = -1; unstable = 0; tmo = 0;
        out_ready = (stall == 0);
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        cyc = 1;
        while (beats < 4 && cyc < 300) begin
            if (done) dones++;
            if (out_valid) begin
                if (lat < 0) lat = cyc;
                if (stall > 0) begin
                    s_pre = out_pre; s_data = out_data; s_idx = out_idx; s_last = out_last;
                    for (int k = 0; k < stall; k++) begin
                        @(negedge clk);
                        cyc++;
                        if (!out_valid || out_pre !== s_pre || out_data !== s_data || out_idx !== s_idx || out_last !== s_last) unstable++;
                    end
                    out_ready = 1'b1;
                end
                got_pre[beats] = out_pre; got_data[beats] = out_data;
                got_idx[beats] = out_idx; got_last[beats] = out_last;
                beat_cyc[beats] = cyc;
                beats++;
                @(negedge clk);
                cyc++;
                if (stall > 0) out_ready = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (beats < 4) tmo = 1;
        done_first = done;
        for (int k = 0; k < 4; k++) begin
            dones += int'(done);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready: got %b expected 1", start_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if ({x_addr, w_addr, b_addr} !== 6'd0) begin n_fail++; $display("FAIL reset_addrs: got x=%0d w=%0d b=%0d expected 0", x_addr, w_addr, b_addr); end
        n_tests++; if ({out_idx, out_last} !== 3'd0) begin n_fail++; $display("FAIL reset_idx_last: got idx=%0d last=%b expected 0", out_idx, out_last); end
        n_tests++; if ({out_pre, out_data} !== 32'd0) begin n_fail++; $display("FAIL reset_data: got pre=%0d data=%0d expected 0", out_pre, out_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic signed [15:0] ep [4];
        logic signed [15:0] ed [4];
        ep = '{16'sd576, -16'sd1024, 16'sd32767, 16'sh8000};
        ed = '{16'sd576, 16'sd0, 16'sd32767, 16'sd0};
        load_basic(16'd256);
        run_pass(0);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL basic_timeout: got %0d beats expected 4", beats); end
        n_tests++; if (lat !== 7) begin n_fail++; $display("FAIL basic_latency: got %0d expected 7", lat); end
        n_tests++; if (beat_cyc[1] !== beat_cyc[0] + 1 || beat_cyc[3] !== beat_cyc[2] + 1) begin n_fail++; $display("FAIL basic_zero_bubble: got %0d,%0d,%0d,%0d expected consecutive pairs", beat_cyc[0], beat_cyc[1], beat_cyc[2], beat_cyc[3]); end
        n_tests++; if (beat_cyc[2] !== 15) begin n_fail++; $display("FAIL basic_group1_start: got %0d expected 15", beat_cyc[2]); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (got_pre[k] !== ep[k]) begin n_fail++; $display("FAIL basic_pre[%0d]: got %0d expected %0d", k, got_pre[k], ep[k]); end
            n_tests++; if (got_data[k] !== ed[k]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, got_data[k], ed[k]); end
        end
        n_tests++; if (done_first !== 1'b1 || dones !== 1) begin n_fail++; $display("FAIL basic_done: got first=%b count=%0d expected 1/1", done_first, dones); end
    endtask

    task automatic test_mixed;
        logic signed [15:0] ep [4];
        logic signed [15:0] ed [4];
        ep = '{-16'sd130, -16'sd1, 16'sd515, 16'sd16};
        ed = '{16'sd0, 16'sd0, 16'sd515, 16'sd16};
        load_mixed();
        run_pass(0);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL mixed_timeout: got %0d beats expected 4", beats); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (got_pre[k] !== ep[k]) begin n_fail++; $display("FAIL mixed_pre[%0d]: got %0d expected %0d", k, got_pre[k], ep[k]); end
            n_tests++; if (got_data[k] !== ed[k]) begin n_fail++; $display("FAIL mixed_data[%0d]: got %0d expected %0d", k, got_data[k], ed[k]); end
        end
    endtask

    task automatic test_saturation;
        logic signed [15:0] ep [4];
        logic signed [15:0] ed [4];
        ep = '{16'sd32767, 16'sh8000, 16'sd32767, 16'sh8000};
        ed = '{16'sd32767, 16'sd0, 16'sd32767, 16'sd0};
        load_basic(16'd32512);
        run_pass(0);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL sat_timeout: got %0d beats expected 4", beats); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (got_pre[k] !== ep[k]) begin n_fail++; $display("FAIL sat_pre[%0d]: got %0d expected %0d", k, got_pre[k], ep[k]); end
            n_tests++; if (got_data[k] !== ed[k]) begin n_fail++; $display("FAIL sat_data[%0d]: got %0d expected %0d", k, got_data[k], ed[k]); end
        end
    endtask

    task automatic test_backpressure;
        logic signed [15:0] ep [4];
        ep = '{16'sd576, -16'sd1024, 16'sd32767, 16'sh8000};
        load_basic(16'd256);
        run_pass(5);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL bp_timeout: got %0d beats expected 4", beats); end
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (got_idx[k] !== 2'(k)) begin n_fail++; $display("FAIL bp_idx[%0d]: got %0d expected %0d", k, got_idx[k], k); end
            n_tests++; if (got_last[k] !== (k == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", k, got_last[k], k == 3); end
            n_tests++; if (got_pre[k] !== ep[k]) begin n_fail++; $display("FAIL bp_pre[%0d]: got %0d expected %0d", k, got_pre[k], ep[k]); end
        end
        n_tests++; if (done_first !== 1'b1 || dones !== 1) begin n_fail++; $display("FAIL bp_done: got first=%b count=%0d expected 1/1", done_first, dones); end
    endtask

    task automatic test_reset_mid;
        int cyc, nv, nd;
        logic signed [15:0] ep [2];
        logic signed [15:0] ed [2];
        ep = '{16'sd576, -16'sd1024};
        ed = '{16'sd576, 16'sd0};
        load_basic(16'd256);
        out_ready = 1'b1;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        cyc = 0;
        while (w_addr !== 3'd6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (w_addr !== 3'd6) begin n_fail++; $display("FAIL mid_reach_acc2: got w_addr=%0d expected 6", w_addr); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_tests++; if (start_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got ready=%b valid=%b expected 1/0", start_ready, out_valid); end
        n_tests++; if ({x_addr, w_addr} !== 5'd0) begin n_fail++; $display("FAIL mid_addrs: got x=%0d w=%0d expected 0", x_addr, w_addr); end
        nv = 0; nd = 0;
        for (int k = 0; k < 20; k++) begin
            nv += int'(out_valid);
            nd += int'(done);
            @(negedge clk);
        end
        n_tests++; if (nv !== 0 || nd !== 0) begin n_fail++; $display("FAIL mid_quiet: got valid=%0d done=%0d expected 0/0", nv, nd); end
        out_ready = 1'b0;
        run_pass(0);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL mid_rerun_timeout: got %0d beats expected 4", beats); end
        for (int k = 0; k < 2; k++) begin
            n_tests++; if (got_pre[k] !== ep[k] || got_data[k] !== ed[k]) begin n_fail++; $display("FAIL mid_rerun[%0d]: got pre=%0d data=%0d expected %0d/%0d", k, got_pre[k], got_data[k], ep[k], ed[k]); end
        end
    endtask

    task automatic test_start_held;
        int cyc, sr, bt, bad, nd, d1, d2;
        load_basic(16'd256);
        cyc = 0; sr = 0; bt = 0; bad = 0; nd = 0; d1 = -1; d2 = -1;
        out_ready = 1'b1;
        start_valid = 1'b1;
        while (nd < 2 && cyc < 200) begin
            sr += int'(start_ready);
            bt += int'(out_valid && out_ready);
            if (out_valid && start_ready) bad++;
            if (done) begin
                nd++;
                if (nd == 1) d1 = cyc; else d2 = cyc;
            end
            if (nd < 2) begin
                @(negedge clk);
                cyc++;
            end
        end
        start_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (nd !== 2) begin n_fail++; $display("FAIL held_done_count: got %0d expected 2", nd); end
        n_tests++; if (d1 !== 17 || d2 - d1 !== 17) begin n_fail++; $display("FAIL held_pass_period: got d1=%0d d2=%0d expected 17/34", d1, d2); end
        n_tests++; if (sr !== 3) begin n_fail++; $display("FAIL held_idle_visits: got %0d expected 3", sr); end
        n_tests++; if (bt !== 8) begin n_fail++; $display("FAIL held_beats: got %0d expected 8", bt); end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL held_ready_in_out: got %0d expected 0", bad); end
    endtask

    initial begin
        reset = 1'b0;
        start_valid = 1'b0;
        out_ready = 1'b0;
        load_basic(16'd256);
        test_reset();
        test_basic();
        test_mixed();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
